// File: rtl/zero_detect_pkg.sv
// rtl/zero_detect_pkg.sv - shared sizing helpers and sideband types for the zero detector
package zero_detect_pkg;

  // Number of RADIX-ary OR levels needed to cover width bits.
  function automatic int num_levels(input int width, input int radix);
    int     lv;
    longint span;
    lv   = 0;
    span = 1;
    for (int i = 0; i < 64; i++) begin
      if (span < longint'(width)) begin
        span = span * radix;
        lv++;
      end
    end
    return lv;
  endfunction

  function automatic int num_stages(input int levels, input int lps);
    return (levels + lps - 1) / lps;
  endfunction

  function automatic int ipow(input int base, input int exp);
    int r;
    r = 1;
    for (int i = 0; i < exp; i++) r = r * base;
    return r;
  endfunction

  typedef struct packed {
    logic valid;
    logic neg;
    logic set_flags;
  } sb_ctrl_t;

endpackage

// File: rtl/or_reduce_level.sv
// rtl/or_reduce_level.sv - one level of the OR tree: RADIX-way OR of adjacent bit groups
module or_reduce_level #(
  parameter int IN_W  = 8,
  parameter int RADIX = 4,
  localparam int OUT_W = (IN_W + RADIX - 1) / RADIX
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  localparam int PAD_W = OUT_W * RADIX;

  logic [PAD_W-1:0] din_pad;

  // Zero padding is neutral for OR, so a ragged top group is safe.
  if (PAD_W > IN_W) begin : g_pad
    assign din_pad = {{(PAD_W - IN_W){1'b0}}, din};
  end else begin : g_nopad
    assign din_pad = din;
  end

  for (genvar i = 0; i < OUT_W; i++) begin : g_node
    assign dout[i] = |din_pad[i*RADIX +: RADIX];
  end

endmodule

// File: rtl/pipelined_zero_detect.sv
// rtl/pipelined_zero_detect.sv - pipelined OR-tree zero detector with sideband and Z/N flags
module pipelined_zero_detect
  import zero_detect_pkg::*;
#(
  parameter int WIDTH            = 64,
  parameter int RADIX            = 4,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int TAG_W            = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_set_flags,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int LEVELS = num_levels(WIDTH, RADIX);
  localparam int STAGES = num_stages(LEVELS, LEVELS_PER_STAGE);
  localparam int PAD_W  = ipow(RADIX, LEVELS);

  typedef struct packed {
    sb_ctrl_t         ctrl;
    logic [TAG_W-1:0] tag;
  } stage_sb_t;

  stage_sb_t        sb_q [STAGES];
  logic [PAD_W-1:0] in_pad;
  logic             adv;
  logic             retire;

  assign adv = !stall && !flush;

  if (PAD_W > WIDTH) begin : g_pad
    assign in_pad = {{(PAD_W - WIDTH){1'b0}}, in_data};
  end else begin : g_nopad
    assign in_pad = in_data;
  end

  // lvl_q is each level's output as seen by the next level: registered at
  // stage boundaries, a plain wire otherwise. The last level stores the NOR.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int IW   = PAD_W / ipow(RADIX, l);
    localparam int OW   = IW / RADIX;
    localparam bit LAST = (l == LEVELS - 1);
    localparam bit REG  = LAST || ((l % LEVELS_PER_STAGE) == LEVELS_PER_STAGE - 1);

    logic [IW-1:0] lvl_in;
    logic [OW-1:0] lvl_or;
    logic [OW-1:0] lvl_q;

    if (l == 0) begin : g_src_in
      assign lvl_in = in_pad;
    end else begin : g_src_prev
      assign lvl_in = g_lvl[l-1].lvl_q;
    end

    or_reduce_level #(
      .IN_W  (IW),
      .RADIX (RADIX)
    ) u_or (
      .din  (lvl_in),
      .dout (lvl_or)
    );

    if (LAST) begin : g_last
      always_ff @(posedge clk) begin
        if (!reset_n)  lvl_q <= '0;
        else if (adv)  lvl_q <= ~lvl_or;
      end
    end else if (REG) begin : g_reg
      always_ff @(posedge clk) begin
        if (!reset_n)  lvl_q <= '0;
        else if (adv)  lvl_q <= lvl_or;
      end
    end else begin : g_comb
      assign lvl_q = lvl_or;
    end
  end

  // Flush only kills valids; payload fields of dead entries are don't-care.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) sb_q[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < STAGES; s++) sb_q[s].ctrl.valid <= 1'b0;
    end else if (!stall) begin
      sb_q[0].ctrl.valid     <= in_valid;
      sb_q[0].ctrl.neg       <= in_data[WIDTH-1];
      sb_q[0].ctrl.set_flags <= in_set_flags;
      sb_q[0].tag            <= in_tag;
      for (int s = 1; s < STAGES; s++) sb_q[s] <= sb_q[s-1];
    end
  end

  assign out_valid = sb_q[STAGES-1].ctrl.valid;
  assign out_neg   = sb_q[STAGES-1].ctrl.neg;
  assign out_tag   = sb_q[STAGES-1].tag;
  assign out_zero  = g_lvl[LEVELS-1].lvl_q[0];

  assign retire = out_valid && sb_q[STAGES-1].ctrl.set_flags && adv;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (retire) begin
      flag_z <= out_zero;
      flag_n <= out_neg;
    end
  end

endmodule

// File: tb/tb_pipelined_zero_detect.sv
// tb/tb_pipelined_zero_detect.sv - directed self-checking bench for pipelined_zero_detect
module tb_pipelined_zero_detect;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_set_flags;
  logic [4:0]  in_tag;
  logic        stall;
  logic        flush;
  logic [63:0] in_data_a;
  logic [39:0] in_data_b;

  logic       out_valid_a, out_zero_a, out_neg_a, flag_z_a, flag_n_a;
  logic [4:0] out_tag_a;
  logic       out_valid_b, out_zero_b, out_neg_b, flag_z_b, flag_n_b;
  logic [4:0] out_tag_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipelined_zero_detect u_dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data_a),
    .in_set_flags (in_set_flags),
    .in_tag       (in_tag),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid_a),
    .out_zero     (out_zero_a),
    .out_neg      (out_neg_a),
    .out_tag      (out_tag_a),
    .flag_z       (flag_z_a),
    .flag_n       (flag_n_a)
  );

  pipelined_zero_detect #(
    .WIDTH            (40),
    .RADIX            (4),
    .LEVELS_PER_STAGE (2),
    .TAG_W            (5)
  ) u_dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data_b),
    .in_set_flags (in_set_flags),
    .in_tag       (in_tag),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid_b),
    .out_zero     (out_zero_b),
    .out_neg      (out_neg_b),
    .out_tag      (out_tag_b),
    .flag_z       (flag_z_b),
    .flag_n       (flag_n_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_set_flags = 1'b0;
    in_tag       = '0;
    in_data_a    = '0;
    in_data_b    = '0;
    stall        = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic drive_a(input logic [63:0] d, input logic [4:0] t, input logic sf);
    in_valid     = 1'b1;
    in_data_a    = d;
    in_data_b    = '0;
    in_tag       = t;
    in_set_flags = sf;
  endtask

  logic [63:0] sv_a [4];
  logic        ez_a [4];
  logic        en_a [4];
  logic [39:0] sv_b [4];
  logic        ez_b [4];
  logic        en_b [4];

  initial begin
    sv_a = '{64'h0, 64'h1, 64'h8000_0000_0000_0000, 64'h0};
    ez_a = '{1'b1, 1'b0, 1'b0, 1'b1};
    en_a = '{1'b0, 1'b0, 1'b1, 1'b0};
    sv_b = '{40'h0, 40'h80_0000_0000, 40'h1, 40'h01_0000_0000};
    ez_b = '{1'b1, 1'b0, 1'b0, 1'b0};
    en_b = '{1'b0, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0;
    idle();
    tick();
    tick();
    check("rst_valid", out_valid_a, 0);
    check("rst_zero",  out_zero_a,  0);
    check("rst_neg",   out_neg_a,   0);
    check("rst_tag",   out_tag_a,   0);
    check("rst_fz",    flag_z_a,    0);
    check("rst_fn",    flag_n_a,    0);
    check("rst_valid_b", out_valid_b, 0);
    check("rst_zero_b",  out_zero_b,  0);
    reset_n = 1'b1;

    // single zero operand, latency 3 then flag update
    drive_a(64'h0, 5'd7, 1'b1);
    tick();
    idle();
    check("t1_lat1", out_valid_a, 0);
    tick();
    check("t1_lat2", out_valid_a, 0);
    tick();
    check("t1_valid", out_valid_a, 1);
    check("t1_zero",  out_zero_a,  1);
    check("t1_neg",   out_neg_a,   0);
    check("t1_tag",   out_tag_a,   7);
    check("t1_fz_pre", flag_z_a,   0);
    tick();
    check("t1_fz",    flag_z_a,    1);
    check("t1_fn",    flag_n_a,    0);
    check("t1_after", out_valid_a, 0);

    // back-to-back stream, strict order
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive_a(sv_a[i], 5'(i + 1), 1'b1);
      else       idle();
      tick();
      if (i >= 2 && i < 6) begin
        check("t2_valid", out_valid_a, 1);
        check("t2_zero",  out_zero_a,  ez_a[i-2]);
        check("t2_neg",   out_neg_a,   en_a[i-2]);
        check("t2_tag",   out_tag_a,   64'(i - 1));
      end else begin
        check("t2_bubble", out_valid_a, 0);
      end
      if (i >= 3 && i < 7) begin
        check("t2_fz", flag_z_a, ez_a[i-3]);
        check("t2_fn", flag_n_a, en_a[i-3]);
      end
    end

    // stall holding a non-zero result at the final stage
    drive_a(64'h1, 5'd9, 1'b1);
    tick();
    idle();
    tick();
    tick();
    check("t3_valid", out_valid_a, 1);
    check("t3_zero",  out_zero_a,  0);
    check("t3_tag",   out_tag_a,   9);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_st_valid", out_valid_a, 1);
      check("t3_st_zero",  out_zero_a,  0);
      check("t3_st_tag",   out_tag_a,   9);
      check("t3_st_fz",    flag_z_a,    1);
      check("t3_st_fn",    flag_n_a,    0);
    end
    stall = 1'b0;
    tick();
    check("t3_ret_fz",  flag_z_a,    0);
    check("t3_ret_fn",  flag_n_a,    0);
    check("t3_ret_val", out_valid_a, 0);

    // flush together with stall, with a new input dropped
    drive_a(64'h8000_0000_0000_0000, 5'd11, 1'b1);
    tick();
    drive_a(64'h0, 5'd12, 1'b1);
    tick();
    idle();
    tick();
    check("t4_pre_valid", out_valid_a, 1);
    check("t4_pre_tag",   out_tag_a,   11);
    drive_a(64'h0, 5'd13, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    idle();
    check("t4_valid", out_valid_a, 0);
    check("t4_fz",    flag_z_a,    0);
    check("t4_fn",    flag_n_a,    0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_drain", out_valid_a, 0);
      check("t4_fz_d",  flag_z_a,    0);
      check("t4_fn_d",  flag_n_a,    0);
    end

    // set-flags entry, then a non-set-flags entry that must not touch flags
    drive_a(64'h8000_0000_0000_0000, 5'd14, 1'b1);
    tick();
    idle();
    tick();
    tick();
    tick();
    check("t5_fz", flag_z_a, 0);
    check("t5_fn", flag_n_a, 1);
    drive_a(64'h0, 5'd15, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check("t5_nsf_valid", out_valid_a, 1);
    check("t5_nsf_zero",  out_zero_a,  1);
    tick();
    check("t5_nsf_fz", flag_z_a, 0);
    check("t5_nsf_fn", flag_n_a, 1);

    // reset with a set-flags entry mid-pipeline
    drive_a(64'h0, 5'd16, 1'b1);
    tick();
    idle();
    tick();
    reset_n = 1'b0;
    tick();
    check("t6_valid", out_valid_a, 0);
    check("t6_zero",  out_zero_a,  0);
    check("t6_neg",   out_neg_a,   0);
    check("t6_tag",   out_tag_a,   0);
    check("t6_fz",    flag_z_a,    0);
    check("t6_fn",    flag_n_a,    0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_none", out_valid_a, 0);
      check("t6_fz_d", flag_z_a,    0);
    end

    // WIDTH=40, LEVELS_PER_STAGE=2 instance: latency 2, padding neutral
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid     = 1'b1;
        in_data_a    = '0;
        in_data_b    = sv_b[i];
        in_tag       = 5'(20 + i);
        in_set_flags = 1'b1;
      end else begin
        idle();
      end
      tick();
      if (i >= 1 && i < 5) begin
        check("b_valid", out_valid_b, 1);
        check("b_zero",  out_zero_b,  ez_b[i-1]);
        check("b_neg",   out_neg_b,   en_b[i-1]);
        check("b_tag",   out_tag_b,   64'(19 + i));
      end else begin
        check("b_bubble", out_valid_b, 0);
      end
      if (i >= 2) begin
        check("b_fz", flag_z_b, ez_b[i-2]);
        check("b_fn", flag_n_b, en_b[i-2]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
